// File: rtl/hazard_pkg.sv
// Shared types for the hazard/branch control block and the fetch stage that consumes branch_ctrl.
package hazard_pkg;

  localparam int unsigned LU_BUBBLES_MAX = 3;
  localparam int unsigned CNT_W          = 2;

  typedef enum logic [1:0] {
    BC_PC4    = 2'b00,
    BC_IMM    = 2'b01,
    BC_IMMRS1 = 2'b10
  } branch_ctrl_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LU_STALL   = 2'b01,
    ST_HOLD_REDIR = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three saturating event counters (load-use stall cycles, redirects, frozen cycles).
module hazard_perf_cnt #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lu_ev_i,
  input  logic              redir_ev_i,
  input  logic              frz_ev_i,
  output logic [PERF_W-1:0] perf_lu_stalls,
  output logic [PERF_W-1:0] perf_redirects,
  output logic [PERF_W-1:0] perf_frozen
);

  logic [PERF_W-1:0] lu_q, redir_q, frz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_q    <= '0;
      redir_q <= '0;
      frz_q   <= '0;
    end else begin
      if (lu_ev_i && (lu_q != '1))       lu_q    <= lu_q + PERF_W'(1);
      if (redir_ev_i && (redir_q != '1)) redir_q <= redir_q + PERF_W'(1);
      if (frz_ev_i && (frz_q != '1))     frz_q   <= frz_q + PERF_W'(1);
    end
  end

  assign perf_lu_stalls = lu_q;
  assign perf_redirects = redir_q;
  assign perf_frozen    = frz_q;

endmodule

// File: rtl/hazard_branch_ctrl.sv
// Redirect / load-use / memory-stall control for the fetch stage; replays redirects that land while PC is frozen.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_branch_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned PERF_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  input  logic            ex_valid,
  input  logic            ex_br_taken,
  input  logic            ex_jalr,
  input  logic [XLEN-1:0] ex_pc_imm,
  input  logic [XLEN-1:0] ex_pc_immrs1,
  input  logic            imem_busy,
  input  logic            dmem_busy,
  output logic [1:0]      branch_ctrl,
  output logic [XLEN-1:0] pc_imm,
  output logic [XLEN-1:0] pc_immrs1,
  output logic            instr_flush,
  output logic            ifid_regwrite,
  output logic            pc_write,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_lu_stalls,
  output logic [PERF_W-1:0] perf_redirects,
  output logic [PERF_W-1:0] perf_frozen,
`endif
  output logic            idex_flush
);

  hz_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  branch_ctrl_e    kind_q, kind_d, kind_c, bc_c;
  logic [XLEN-1:0] imm_q, imm_d, rs1_q, rs1_d, rs1_tgt_c;
  logic            redirect_c, frozen_c, load_use_c;

  assign redirect_c = ex_valid & (ex_br_taken | ex_jalr);
  assign kind_c     = ex_jalr ? BC_IMMRS1 : BC_IMM;
  assign frozen_c   = imem_busy | dmem_busy;
  assign rs1_tgt_c  = ex_pc_immrs1 & ~XLEN'(1);
  assign load_use_c = ex_memread & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      kind_q  <= BC_PC4;
      imm_q   <= '0;
      rs1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
    end
  end

  // Next state and fetch controls; priority dmem_busy > redirect > load-use > imem_busy.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    kind_d        = kind_q;
    imm_d         = imm_q;
    rs1_d         = rs1_q;
    bc_c          = BC_PC4;
    pc_imm        = imm_q;
    pc_immrs1     = rs1_q;
    instr_flush   = 1'b0;
    idex_flush    = 1'b0;
    ifid_regwrite = 1'b1;
    pc_write      = 1'b1;

    unique case (state_q)
      ST_RUN, ST_LU_STALL: begin
        if (redirect_c && frozen_c) begin
          // Park the redirect until fetch can take it.
          pc_write      = 1'b0;
          ifid_regwrite = 1'b0;
          kind_d        = kind_c;
          imm_d         = ex_pc_imm;
          rs1_d         = rs1_tgt_c;
          cnt_d         = '0;
          state_d       = ST_HOLD_REDIR;
        end else if (dmem_busy) begin
          pc_write      = 1'b0;
          ifid_regwrite = 1'b0;
        end else if (redirect_c) begin
          bc_c        = kind_c;
          pc_imm      = ex_pc_imm;
          pc_immrs1   = rs1_tgt_c;
          instr_flush = 1'b1;
          idex_flush  = 1'b1;
          kind_d      = kind_c;
          imm_d       = ex_pc_imm;
          rs1_d       = rs1_tgt_c;
          cnt_d       = '0;
          state_d     = ST_RUN;
        end else if (state_q == ST_LU_STALL) begin
          pc_write      = 1'b0;
          ifid_regwrite = 1'b0;
          idex_flush    = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (load_use_c) begin
          pc_write      = 1'b0;
          ifid_regwrite = 1'b0;
          idex_flush    = 1'b1;
          if (LU_BUBBLES > 1) begin
            cnt_d   = CNT_W'(LU_BUBBLES - 1);
            state_d = ST_LU_STALL;
          end
        end else if (imem_busy) begin
          // Bubble ID/EX so the held IF/ID instruction is not issued twice.
          pc_write      = 1'b0;
          ifid_regwrite = 1'b0;
          idex_flush    = 1'b1;
        end
      end

      ST_HOLD_REDIR: begin
        if (frozen_c) begin
          pc_write      = 1'b0;
          ifid_regwrite = 1'b0;
        end else begin
          bc_c        = kind_q;
          instr_flush = 1'b1;
          idex_flush  = 1'b1;
          state_d     = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign branch_ctrl = 2'(bc_c);

`ifdef HAZARD_PERF_CNT_EN
  logic lu_ev_c, redir_ev_c;

  assign redir_ev_c = (state_q != ST_HOLD_REDIR) & redirect_c;
  assign lu_ev_c    = ~redirect_c & ~dmem_busy &
                      ((state_q == ST_LU_STALL) | ((state_q == ST_RUN) & load_use_c));

  hazard_perf_cnt #(
    .PERF_W(PERF_W)
  ) u_perf (
    .clk            (clk),
    .rst            (rst),
    .lu_ev_i        (lu_ev_c),
    .redir_ev_i     (redir_ev_c),
    .frz_ev_i       (frozen_c),
    .perf_lu_stalls (perf_lu_stalls),
    .perf_redirects (perf_redirects),
    .perf_frozen    (perf_frozen)
  );
`endif

endmodule
